calc_entry_fsm: RTL and testbench

CALC_ENTRY_FSM -- requirements
Module: calc_entry_fsm

---
 rtl/calc_pkg.sv | 38 +++
 rtl/bcd_digit_reg.sv | 58 +++++
 rtl/calc_entry_fsm.sv | 182 ++++++++++++++++++
 tb/tb_calc_entry_fsm.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/calc_pkg.sv
// +----------------------------------------------------------------------------+
// | calc_pkg: shared key codes, ALU operation codes and FSM states              |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

package calc_pkg;

  localparam logic [3:0] KEY_PLUS  = 4'hA;
  localparam logic [3:0] KEY_MINUS = 4'hB;
  localparam logic [3:0] KEY_EQ    = 4'hC;
  localparam logic [3:0] KEY_CLR   = 4'hD;

  localparam logic [1:0] OP_NONE = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;

  localparam logic [2:0] MAX_DIGITS = 3'd4;

  typedef enum logic [2:0] {
    S_NUM1   = 3'd0,
    S_OP     = 3'd1,
    S_NUM2   = 3'd2,
    S_WAIT   = 3'd3,
    S_RESULT = 3'd4
  } state_t;

  function automatic logic is_digit(input logic [3:0] key);
    return key <= 4'h9;
  endfunction

  function automatic logic [1:0] op_of_key(input logic [3:0] key);
    return (key == KEY_MINUS) ? OP_SUB : OP_ADD;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_reg.sv
// +----------------------------------------------------------------------------+
// | bcd_digit_reg: 4-digit BCD entry register with clear, set, restart-load     |
// | and shift-in of a digit, guarded by a saturating digit count. Rev 1.0       |
// +----------------------------------------------------------------------------+
`default_nettype none

module bcd_digit_reg (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        set,
  input  logic        load,
  input  logic        shift,
  input  logic [3:0]  digit,
  input  logic [15:0] set_value,
  output logic [15:0] value,
  output logic [15:0] value_next
);
  import calc_pkg::*;

  logic [15:0] r_value;
  logic [2:0]  r_count;
  logic [2:0]  w_count_next;

  // Priority: clear, whole-value set, restart with one digit, then shift-in.
  always_comb begin
    value_next   = r_value;
    w_count_next = r_count;
    if (clr) begin
      value_next   = 16'h0000;
      w_count_next = 3'd0;
    end else if (set) begin
      value_next   = set_value;
      w_count_next = MAX_DIGITS;
    end else if (load) begin
      value_next   = {12'h000, digit};
      w_count_next = 3'd1;
    end else if (shift && (r_count < MAX_DIGITS)) begin
      value_next   = {r_value[11:0], digit};
      w_count_next = r_count + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_value <= 16'h0000;
      r_count <= 3'd0;
    end else begin
      r_value <= value_next;
      r_count <= w_count_next;
    end
  end

  assign value = r_value;

endmodule

`default_nettype wire

// File: rtl/calc_entry_fsm.sv
// +----------------------------------------------------------------------------+
// | calc_entry_fsm: keypad entry FSM feeding a BCD ALU and a 4-digit display.   |
// | Option CALC_CHAIN_RESULT_EN: +/- after a result chains it as operand 1.     |
// | Rev 1.0                                                                      |
// +----------------------------------------------------------------------------+
`default_nettype none

module calc_entry_fsm #(
  parameter int ALU_LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [15:0] alu_result,
  output logic [15:0] num1_bcd,
  output logic [15:0] num2_bcd,
  output logic [1:0]  operation,
  output logic [15:0] display_bcd,
  output logic        result_valid
);
  import calc_pkg::*;

  localparam int WAIT_W = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LOAD = WAIT_W'(ALU_LATENCY - 1);

  state_t            r_state, w_state_next;
  logic [1:0]        r_op, w_op_next;
  logic [WAIT_W-1:0] r_wait_cnt, w_wait_next;
  logic [15:0]       r_result, w_result_next;
  logic [15:0]       r_display, w_display_next;
  logic              r_result_valid, w_result_valid_next;

  logic              w_n1_clr, w_n1_set, w_n1_load, w_n1_shift;
  logic              w_n2_clr, w_n2_load, w_n2_shift;
  logic [15:0]       w_n1_next, w_n2_next;
  logic              w_key_digit, w_key_op;

  assign w_key_digit = is_digit(key_code);
  assign w_key_op    = (key_code == KEY_PLUS) || (key_code == KEY_MINUS);

  bcd_digit_reg u_num1 (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_n1_clr),
    .set        (w_n1_set),
    .load       (w_n1_load),
    .shift      (w_n1_shift),
    .digit      (key_code),
    .set_value  (r_result),
    .value      (num1_bcd),
    .value_next (w_n1_next)
  );

  bcd_digit_reg u_num2 (
    .clk        (clk),
    .rst        (rst),
    .clr        (w_n2_clr),
    .set        (1'b0),
    .load       (w_n2_load),
    .shift      (w_n2_shift),
    .digit      (key_code),
    .set_value  (16'h0000),
    .value      (num2_bcd),
    .value_next (w_n2_next)
  );

  always_comb begin
    w_state_next        = r_state;
    w_op_next           = r_op;
    w_wait_next         = r_wait_cnt;
    w_result_next       = r_result;
    w_result_valid_next = 1'b0;
    w_n1_clr            = 1'b0;
    w_n1_set            = 1'b0;
    w_n1_load           = 1'b0;
    w_n1_shift          = 1'b0;
    w_n2_clr            = 1'b0;
    w_n2_load           = 1'b0;
    w_n2_shift          = 1'b0;

    // S_WAIT runs on the counter alone; every key, clear included, is dropped.
    if (r_state == S_WAIT) begin
      if (r_wait_cnt == '0) begin
        w_result_next       = alu_result;
        w_result_valid_next = 1'b1;
        w_state_next        = S_RESULT;
      end else begin
        w_wait_next = r_wait_cnt - WAIT_W'(1);
      end
    end else if (key_valid) begin
      if (key_code == KEY_CLR) begin
        w_state_next  = S_NUM1;
        w_op_next     = OP_NONE;
        w_wait_next   = '0;
        w_result_next = 16'h0000;
        w_n1_clr      = 1'b1;
        w_n2_clr      = 1'b1;
      end else begin
        case (r_state)
          S_NUM1: begin
            if (w_key_digit) begin
              w_n1_shift = 1'b1;
            end else if (w_key_op) begin
              w_op_next    = op_of_key(key_code);
              w_n2_clr     = 1'b1;
              w_state_next = S_OP;
            end
          end
          S_OP: begin
            if (w_key_digit) begin
              w_n2_load    = 1'b1;
              w_state_next = S_NUM2;
            end else if (w_key_op) begin
              w_op_next = op_of_key(key_code);
            end
          end
          S_NUM2: begin
            if (w_key_digit) begin
              w_n2_shift = 1'b1;
            end else if (w_key_op) begin
              w_op_next = op_of_key(key_code);
            end else if (key_code == KEY_EQ) begin
              w_wait_next  = WAIT_LOAD;
              w_state_next = S_WAIT;
            end
          end
          S_RESULT: begin
            if (w_key_digit) begin
              w_n1_load    = 1'b1;
              w_n2_clr     = 1'b1;
              w_op_next    = OP_NONE;
              w_state_next = S_NUM1;
            end else if (w_key_op) begin
`ifdef CALC_CHAIN_RESULT_EN
              w_n1_set     = 1'b1;
              w_n2_clr     = 1'b1;
              w_op_next    = op_of_key(key_code);
              w_state_next = S_OP;
`endif
            end
          end
          default: w_state_next = S_NUM1;
        endcase
      end
    end
  end

  // Display is registered from next-cycle values so it tracks the state it shows.
  always_comb begin
    case (w_state_next)
      S_NUM1, S_OP: w_display_next = w_n1_next;
      S_NUM2:       w_display_next = w_n2_next;
      default:      w_display_next = w_result_next;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= S_NUM1;
      r_op           <= OP_NONE;
      r_wait_cnt     <= '0;
      r_result       <= 16'h0000;
      r_display      <= 16'h0000;
      r_result_valid <= 1'b0;
    end else begin
      r_state        <= w_state_next;
      r_op           <= w_op_next;
      r_wait_cnt     <= w_wait_next;
      r_result       <= w_result_next;
      r_display      <= w_display_next;
      r_result_valid <= w_result_valid_next;
    end
  end

  assign operation    = r_op;
  assign display_bcd  = r_display;
  assign result_valid = r_result_valid;

endmodule

`default_nettype wire

// File: tb/tb_calc_entry_fsm.sv
// Scoreboard bench for calc_entry_fsm with a 2-stage saturating BCD ALU model.
// Define CALC_CHAIN_RESULT_EN for both bench and RTL to exercise result chaining.
`timescale 1ns/1ps
`default_nettype none

module tb_calc_entry_fsm;
  import calc_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [15:0] alu_result;
  logic [15:0] num1_bcd, num2_bcd, display_bcd;
  logic [1:0]  operation;
  logic        result_valid;
  logic        snap_req;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        is_result;
    logic [15:0] n1;
    logic [15:0] n2;
    logic [1:0]  op;
    logic [15:0] disp;
  } exp_t;

  exp_t q[$];
  exp_t e;

  calc_entry_fsm #(.ALU_LATENCY(2)) dut (
    .clk          (clk),
    .rst          (rst),
    .key_valid    (key_valid),
    .key_code     (key_code),
    .alu_result   (alu_result),
    .num1_bcd     (num1_bcd),
    .num2_bcd     (num2_bcd),
    .operation    (operation),
    .display_bcd  (display_bcd),
    .result_valid (result_valid)
  );

  always #5 clk = ~clk;

  // Downstream ALU model: saturating BCD add/sub with a 2-cycle pipeline.
  function automatic int bcd2bin(input logic [15:0] b);
    return b[15:12] * 1000 + b[11:8] * 100 + b[7:4] * 10 + b[3:0];
  endfunction

  function automatic logic [15:0] bin2bcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [1:0] op);
    int x, y, s;
    x = bcd2bin(a);
    y = bcd2bin(b);
    if (op == 2'b01) s = (x + y > 9999) ? 9999 : x + y;
    else if (op == 2'b10) s = (x < y) ? 0 : x - y;
    else s = 0;
    return bin2bcd(s);
  endfunction

  logic [15:0] alu_s1 = 16'h0;
  always @(posedge clk) begin
    alu_s1     <= alu_f(num1_bcd, num2_bcd, operation);
    alu_result <= alu_s1;
  end

  task automatic cmp(input string nm, input string fld, input logic [15:0] got,
                     input logic [15:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h expected %h", nm, fld, got, want);
    end
  endtask

  // Monitor: pops an expectation whenever the DUT pulses result_valid or a snapshot is requested.
  always @(negedge clk) begin
    if (result_valid === 1'b1 || snap_req) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output: result_valid=%b display=%h with nothing expected",
                 result_valid, display_bcd);
      end else begin
        e = q.pop_front();
        cmp(e.name, "result_valid", {15'h0, result_valid}, {15'h0, e.is_result});
        cmp(e.name, "num1", num1_bcd, e.n1);
        cmp(e.name, "num2", num2_bcd, e.n2);
        cmp(e.name, "op", {14'h0, operation}, {14'h0, e.op});
        cmp(e.name, "display", display_bcd, e.disp);
      end
    end
  end

  task automatic press(input logic [3:0] k);
    @(posedge clk);
    #1 key_valid = 1'b1;
    key_code = k;
    @(posedge clk);
    #1 key_valid = 1'b0;
    key_code = 4'h0;
  endtask

  task automatic snap(input string nm, input logic [15:0] n1, input logic [15:0] n2,
                      input logic [1:0] op, input logic [15:0] disp);
    q.push_back('{nm, 1'b0, n1, n2, op, disp});
    snap_req = 1'b1;
    @(negedge clk);
    #1 snap_req = 1'b0;
  endtask

  task automatic expect_result(input string nm, input logic [15:0] n1, input logic [15:0] n2,
                               input logic [1:0] op, input logic [15:0] disp);
    q.push_back('{nm, 1'b1, n1, n2, op, disp});
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 20 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL %s.timeout: %0d expectations still pending, expected 0", nm, q.size());
      q.delete();
    end
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    key_valid = 1'b0;
    key_code = 4'h0;
    snap_req = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    snap("reset", 16'h0000, 16'h0000, 2'b00, 16'h0000);
    press(4'hE);
    press(4'hF);
    press(KEY_EQ);
    snap("unused_keys", 16'h0000, 16'h0000, 2'b00, 16'h0000);

    // 12 + 34 = 46 with two S_WAIT cycles before the pulse
    press(4'h1); press(4'h2);
    snap("num1_12", 16'h0012, 16'h0000, 2'b00, 16'h0012);
    press(KEY_PLUS);
    snap("op_add", 16'h0012, 16'h0000, 2'b01, 16'h0012);
    press(4'h3); press(4'h4);
    snap("num2_34", 16'h0012, 16'h0034, 2'b01, 16'h0034);
    press(KEY_EQ);
    snap("wait_cyc1", 16'h0012, 16'h0034, 2'b01, 16'h0000);
    snap("wait_cyc2", 16'h0012, 16'h0034, 2'b01, 16'h0000);
    expect_result("res_46", 16'h0012, 16'h0034, 2'b01, 16'h0046);
    drain("res_46");
    snap("after_pulse", 16'h0012, 16'h0034, 2'b01, 16'h0046);

    // Digit saturation and ALU overflow saturation
    press(4'h9);
    snap("restart_9", 16'h0009, 16'h0000, 2'b00, 16'h0009);
    press(4'h9); press(4'h9); press(4'h9);
    snap("num1_9999", 16'h9999, 16'h0000, 2'b00, 16'h9999);
    press(4'h9);
    snap("fifth_digit", 16'h9999, 16'h0000, 2'b00, 16'h9999);
    press(KEY_PLUS); press(4'h1); press(KEY_EQ);
    expect_result("res_sat_hi", 16'h9999, 16'h0001, 2'b01, 16'h9999);
    drain("res_sat_hi");

    // Operator overwrite and underflow saturation
    press(4'h5); press(KEY_PLUS); press(KEY_MINUS);
    snap("op_overwrite", 16'h0005, 16'h0000, 2'b10, 16'h0005);
    press(4'h7);
    snap("num2_7", 16'h0005, 16'h0007, 2'b10, 16'h0007);
    press(KEY_EQ);
    expect_result("res_sat_lo", 16'h0005, 16'h0007, 2'b10, 16'h0000);
    drain("res_sat_lo");

    // Clear in S_NUM2, then clear ignored during S_WAIT
    press(KEY_CLR);
    snap("clr_result", 16'h0000, 16'h0000, 2'b00, 16'h0000);
    press(4'h4); press(4'h2); press(KEY_PLUS); press(4'h1);
    snap("num2_1", 16'h0042, 16'h0001, 2'b01, 16'h0001);
    press(KEY_CLR);
    snap("clr_num2", 16'h0000, 16'h0000, 2'b00, 16'h0000);
    press(4'h4); press(4'h2); press(KEY_PLUS); press(4'h1); press(KEY_EQ);
    expect_result("res_43", 16'h0042, 16'h0001, 2'b01, 16'h0043);
    press(KEY_CLR);
    drain("res_43");
    snap("clr_in_wait", 16'h0042, 16'h0001, 2'b01, 16'h0043);

    // Reset on the second S_WAIT cycle, with a key in the same cycle
    press(4'h2); press(KEY_PLUS); press(4'h3); press(KEY_EQ);
    snap("wait_show_last", 16'h0002, 16'h0003, 2'b01, 16'h0043);
    @(posedge clk);
    #1 rst = 1'b1;
    key_valid = 1'b1;
    key_code = 4'h5;
    @(posedge clk);
    #1 rst = 1'b0;
    key_valid = 1'b0;
    key_code = 4'h0;
    snap("rst_in_wait", 16'h0000, 16'h0000, 2'b00, 16'h0000);
    repeat (5) @(posedge clk);
    #1 snap("rst_no_pulse", 16'h0000, 16'h0000, 2'b00, 16'h0000);

    // Result chaining (build dependent)
    press(4'h2); press(KEY_PLUS); press(4'h3); press(KEY_EQ);
    expect_result("res_5", 16'h0002, 16'h0003, 2'b01, 16'h0005);
    drain("res_5");
    press(KEY_PLUS);
`ifdef CALC_CHAIN_RESULT_EN
    snap("chain_op", 16'h0005, 16'h0000, 2'b01, 16'h0005);
    press(KEY_EQ);
    snap("eq_in_op", 16'h0005, 16'h0000, 2'b01, 16'h0005);
    press(4'h6);
    snap("chain_num2", 16'h0005, 16'h0006, 2'b01, 16'h0006);
`else
    snap("no_chain", 16'h0002, 16'h0003, 2'b01, 16'h0005);
    press(4'h6);
    snap("still_result", 16'h0006, 16'h0000, 2'b00, 16'h0006);
`endif

    drain("final");
    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
